// File: rtl/btn_pulse_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, tick-gated debounce, rising-edge capture and a
// lowest-index-first arbiter that releases one-hot single-cycle pulses. Optional: BTN_AUTOREPEAT_EN.
module btn_pulse_conditioner #(
    parameter int N_BTN        = 6,
    parameter int DB_TICKS     = 4,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             drop_err
);

    localparam logic [7:0] DB_LIM = 8'(DB_TICKS);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_pend;
    logic [N_BTN-1:0] r_pulse;
    logic             r_drop;
    logic [7:0]       r_cnt [N_BTN];

    logic [7:0]       w_cnt_nxt [N_BTN];
    logic [N_BTN-1:0] w_level_nxt;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_rep_set;
    logic [N_BTN-1:0] w_set;
    logic [N_BTN-1:0] w_grant;
    logic [N_BTN-1:0] w_pend_nxt;
    logic             w_drop_nxt;

    // NOTE: every signal gets its hold value before any condition, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            w_cnt_nxt[i]   = r_cnt[i];
            w_level_nxt[i] = r_level[i];
            if (tick) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_cnt[i] == DB_LIM - 8'd1) begin
                        w_level_nxt[i] = ~r_level[i];
                        w_cnt_nxt[i]   = 8'd0;
                    end else if (r_cnt[i] != 8'hFF) begin
                        w_cnt_nxt[i] = r_cnt[i] + 8'd1;
                    end
                end else begin
                    w_cnt_nxt[i] = 8'd0;
                end
            end
        end
    end

    // Rise is taken from the next level so pend sets on the same edge the level rises.
    assign w_rise = w_level_nxt & ~r_level;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [9:0] HOLD_LIM = 10'(HOLD_TICKS);
    localparam logic [9:0] REP_LIM  = 10'(REPEAT_TICKS);

    logic [9:0]       r_rep_cnt [N_BTN];
    logic [N_BTN-1:0] r_rep_phase;
    logic [9:0]       w_rep_cnt_nxt [N_BTN];
    logic [N_BTN-1:0] w_rep_phase_nxt;
    logic [9:0]       w_rep_lim;

    always_comb begin
        w_rep_set       = '0;
        w_rep_phase_nxt = r_rep_phase;
        w_rep_lim       = HOLD_LIM;
        for (int i = 0; i < N_BTN; i++) begin
            w_rep_cnt_nxt[i] = r_rep_cnt[i];
            w_rep_lim        = r_rep_phase[i] ? REP_LIM : HOLD_LIM;
            if (!r_level[i]) begin
                w_rep_cnt_nxt[i]   = 10'd0;
                w_rep_phase_nxt[i] = 1'b0;
            end else if (tick) begin
                if (r_rep_cnt[i] == w_rep_lim - 10'd1) begin
                    w_rep_set[i]       = 1'b1;
                    w_rep_cnt_nxt[i]   = 10'd0;
                    w_rep_phase_nxt[i] = 1'b1;
                end else begin
                    w_rep_cnt_nxt[i] = r_rep_cnt[i] + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_rep_phase <= '0;
            for (int i = 0; i < N_BTN; i++) r_rep_cnt[i] <= 10'd0;
        end else begin
            r_rep_phase <= w_rep_phase_nxt;
            for (int i = 0; i < N_BTN; i++) r_rep_cnt[i] <= w_rep_cnt_nxt[i];
        end
    end
`else
    assign w_rep_set = '0;
`endif

    // Lowest pending index wins; a fresh set of the granted bit survives the clear.
    always_comb begin
        w_grant = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end

    assign w_set      = w_rise | w_rep_set;
    assign w_pend_nxt = (r_pend & ~w_grant) | w_set;
    assign w_drop_nxt = r_drop | (|(w_set & r_pend & ~w_grant));

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_pend  <= '0;
            r_pulse <= '0;
            r_drop  <= 1'b0;
            // NOTE: the counter array is plain flops, so it is cleared by reset like any other state.
            for (int i = 0; i < N_BTN; i++) r_cnt[i] <= 8'd0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
            r_pend  <= w_pend_nxt;
            r_pulse <= w_grant;
            r_drop  <= w_drop_nxt;
            for (int i = 0; i < N_BTN; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;
    assign drop_err  = r_drop;

endmodule
